// File: rtl/sticky_shift_clz_unit.sv
// sticky_shift_clz_unit
// ---------------------
// Registered datapath helper for the posit adder. Two independent lanes share
// only the input qualifier:
//   * shift lane : right shift of an MSB-aligned fraction. It also reports the
//                  OR (sticky) and AND (sticky_and) of every bit shifted out.
//   * count lane : leading-zero count used for renormalisation.
// Both lanes are combinational. A single output register stage gives a fixed
// latency of one cycle.
//
// Ports
//   clock       in   rising-edge clock
//   resetn      in   asynchronous active-low reset; clears every output
//   in_valid    in   qualifies shift_data / shift_amt / clz_data this cycle
//   shift_data  in   [IN_WIDTH-1:0]       value to shift right
//   shift_amt   in   [SHIFT_VAL_WIDTH-1:0] unsigned shift distance
//   clz_data    in   [CLZ_WIDTH-1:0]      value whose leading zeros are counted
//   out_valid   out  registered copy of in_valid
//   shift_out   out  [OUT_WIDTH-1:0]      shifted value
//   sticky      out  OR of the shifted-out bits
//   sticky_and  out  AND of the shifted-out bits (1 when nothing is shifted out)
//   clz_count   out  [CLZ_OUT_WIDTH-1:0]  leading-zero count of clz_data
module sticky_shift_clz_unit #(
    parameter int IN_WIDTH        = 8,
    parameter int OUT_WIDTH       = 8,
    parameter int SHIFT_VAL_WIDTH = 4,
    parameter int CLZ_WIDTH       = 8,
    localparam int CLZ_OUT_WIDTH  = $clog2(CLZ_WIDTH + 1)
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       in_valid,
    input  logic [IN_WIDTH-1:0]        shift_data,
    input  logic [SHIFT_VAL_WIDTH-1:0] shift_amt,
    input  logic [CLZ_WIDTH-1:0]       clz_data,
    output logic                       out_valid,
    output logic [OUT_WIDTH-1:0]       shift_out,
    output logic                       sticky,
    output logic                       sticky_and,
    output logic [CLZ_OUT_WIDTH-1:0]   clz_count
);

    generate
        if (OUT_WIDTH < IN_WIDTH) begin : gWidthCheck
            $error("sticky_shift_clz_unit: OUT_WIDTH must be >= IN_WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Shift lane
    // ------------------------------------------------------------------
    // The input sits in the upper bits. The zero padding below it counts as
    // real shifted-out bits for the sticky flags.
    logic [OUT_WIDTH-1:0] extended;
    logic [31:0]          shiftAmtExt;
    logic [OUT_WIDTH-1:0] shiftMask;
    logic [OUT_WIDTH-1:0] shiftOutNext;
    logic                 stickyNext;
    logic                 stickyAndNext;

    assign extended    = OUT_WIDTH'(shift_data) << (OUT_WIDTH - IN_WIDTH);
    assign shiftAmtExt = 32'(shift_amt);

    // Bit gi of the mask is set when position gi leaves the word. Oversized
    // shifts set every bit. This gives the saturating behaviour without a
    // separate compare-and-select path.
    generate
        for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : gShiftMask
            assign shiftMask[gi] = (shiftAmtExt > 32'(gi));
        end
    endgenerate

    // A logical right shift by at least the word width already yields zero.
    assign shiftOutNext  = extended >> shift_amt;
    assign stickyNext    = |(extended & shiftMask);
    // Bits that are not shifted out are forced to 1. An empty set therefore
    // reduces to 1.
    assign stickyAndNext = &(extended | ~shiftMask);

    // ------------------------------------------------------------------
    // Count lane: priority encoder. The highest set bit is visited last,
    // so its count is the one that remains.
    // ------------------------------------------------------------------
    logic [CLZ_OUT_WIDTH-1:0] clzCountNext;

    always_comb begin
        clzCountNext = CLZ_OUT_WIDTH'(CLZ_WIDTH);
        for (int i = 0; i < CLZ_WIDTH; i++) begin
            if (clz_data[i]) begin
                clzCountNext = CLZ_OUT_WIDTH'(CLZ_WIDTH - 1 - i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic                     outValidReg;
    logic [OUT_WIDTH-1:0]     shiftOutReg;
    logic                     stickyReg;
    logic                     stickyAndReg;
    logic [CLZ_OUT_WIDTH-1:0] clzCountReg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            outValidReg  <= 1'b0;
            shiftOutReg  <= '0;
            stickyReg    <= 1'b0;
            stickyAndReg <= 1'b0;
            clzCountReg  <= '0;
        end else begin
            outValidReg <= in_valid;
            // Results hold their last value until the next qualified input.
            if (in_valid) begin
                shiftOutReg  <= shiftOutNext;
                stickyReg    <= stickyNext;
                stickyAndReg <= stickyAndNext;
                clzCountReg  <= clzCountNext;
            end
        end
    end

    assign out_valid  = outValidReg;
    assign shift_out  = shiftOutReg;
    assign sticky     = stickyReg;
    assign sticky_and = stickyAndReg;
    assign clz_count  = clzCountReg;

endmodule

// File: tb/tb_sticky_shift_clz_unit.sv
// Testbench for sticky_shift_clz_unit. It runs two instances side by side:
// one with the default 8/8/4/8 parameters, and one padded instance with
// IN=4, OUT=6, SHIFT=3 and CLZ=5. Every output is compared each cycle
// against an arithmetic reference model.
module tb_sticky_shift_clz_unit;

    localparam int IW  = 8, OW  = 8, SW  = 4, CW  = 8, COW  = $clog2(CW + 1);
    localparam int PIW = 4, POW = 6, PSW = 3, PCW = 5, PCOW = $clog2(PCW + 1);

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic inValid = 1'b0;

    always #5 clock = ~clock;

    // default instance
    logic [IW-1:0]   shiftData;
    logic [SW-1:0]   shiftAmt;
    logic [CW-1:0]   clzData;
    logic            outValid;
    logic [OW-1:0]   shiftOut;
    logic            sticky;
    logic            stickyAnd;
    logic [COW-1:0]  clzCount;

    // padded instance
    logic [PIW-1:0]  pShiftData;
    logic [PSW-1:0]  pShiftAmt;
    logic [PCW-1:0]  pClzData;
    logic            pOutValid;
    logic [POW-1:0]  pShiftOut;
    logic            pSticky;
    logic            pStickyAnd;
    logic [PCOW-1:0] pClzCount;

    sticky_shift_clz_unit dut (
        .clock(clock), .resetn(resetn), .in_valid(inValid),
        .shift_data(shiftData), .shift_amt(shiftAmt), .clz_data(clzData),
        .out_valid(outValid), .shift_out(shiftOut), .sticky(sticky),
        .sticky_and(stickyAnd), .clz_count(clzCount)
    );

    sticky_shift_clz_unit #(
        .IN_WIDTH(PIW), .OUT_WIDTH(POW), .SHIFT_VAL_WIDTH(PSW), .CLZ_WIDTH(PCW)
    ) dutPad (
        .clock(clock), .resetn(resetn), .in_valid(inValid),
        .shift_data(pShiftData), .shift_amt(pShiftAmt), .clz_data(pClzData),
        .out_valid(pOutValid), .shift_out(pShiftOut), .sticky(pSticky),
        .sticky_and(pStickyAnd), .clz_count(pClzCount)
    );

    int compareCount  = 0;
    int mismatchCount = 0;

    // expected register contents
    int eValid, eShift, eSticky, eStickyAnd, eClz;
    int pValid, pShift, pStick, pStickAnd, pClz;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the MSB-aligned value.
    function automatic int refExt(input int data, input int iw, input int ow);
        return data * (1 << (ow - iw));
    endfunction

    function automatic int refShift(input int data, input int amt, input int iw, input int ow);
        if (amt >= ow) return 0;
        return refExt(data, iw, ow) / (1 << amt);
    endfunction

    // The bits shifted out are the remainder modulo 2^k, where k = min(amt, ow).
    function automatic int refLost(input int data, input int amt, input int iw, input int ow);
        int k;
        k = (amt < ow) ? amt : ow;
        return refExt(data, iw, ow) % (1 << k);
    endfunction

    function automatic int refSticky(input int data, input int amt, input int iw, input int ow);
        return (refLost(data, amt, iw, ow) != 0) ? 1 : 0;
    endfunction

    function automatic int refStickyAnd(input int data, input int amt, input int iw, input int ow);
        int k;
        k = (amt < ow) ? amt : ow;
        return (refLost(data, amt, iw, ow) == (1 << k) - 1) ? 1 : 0;
    endfunction

    // The leading-zero count is the width minus the bit length of the value.
    function automatic int refClz(input int data, input int w);
        return w - $clog2(data + 1);
    endfunction

    task automatic clearModel();
        eValid = 0; eShift = 0; eSticky = 0; eStickyAnd = 0; eClz = 0;
        pValid = 0; pShift = 0; pStick = 0; pStickAnd = 0; pClz = 0;
    endtask

    task automatic checkAll(input string tag);
        checkVal({tag, ".out_valid"},   32'(outValid),   32'(eValid));
        checkVal({tag, ".shift_out"},   32'(shiftOut),   32'(eShift));
        checkVal({tag, ".sticky"},      32'(sticky),     32'(eSticky));
        checkVal({tag, ".sticky_and"},  32'(stickyAnd),  32'(eStickyAnd));
        checkVal({tag, ".clz_count"},   32'(clzCount),   32'(eClz));
        checkVal({tag, ".p_out_valid"}, 32'(pOutValid),  32'(pValid));
        checkVal({tag, ".p_shift_out"}, 32'(pShiftOut),  32'(pShift));
        checkVal({tag, ".p_sticky"},    32'(pSticky),    32'(pStick));
        checkVal({tag, ".p_sticky_and"},32'(pStickyAnd), 32'(pStickAnd));
        checkVal({tag, ".p_clz_count"}, 32'(pClzCount),  32'(pClz));
    endtask

    task automatic randomizeInputs();
        shiftData  = IW'($urandom);
        shiftAmt   = SW'($urandom);
        clzData    = CW'($urandom);
        pShiftData = PIW'($urandom);
        pShiftAmt  = PSW'($urandom);
        pClzData   = PCW'($urandom);
    endtask

    // Waits for the sampling edge, updates the model from the driven inputs,
    // then checks every output.
    task automatic sampleAndCheck(input string tag);
        @(posedge clock);
        eValid = int'(inValid);
        pValid = int'(inValid);
        if (inValid) begin
            eShift     = refShift(int'(shiftData), int'(shiftAmt), IW, OW);
            eSticky    = refSticky(int'(shiftData), int'(shiftAmt), IW, OW);
            eStickyAnd = refStickyAnd(int'(shiftData), int'(shiftAmt), IW, OW);
            eClz       = refClz(int'(clzData), CW);
            pShift     = refShift(int'(pShiftData), int'(pShiftAmt), PIW, POW);
            pStick     = refSticky(int'(pShiftData), int'(pShiftAmt), PIW, POW);
            pStickAnd  = refStickyAnd(int'(pShiftData), int'(pShiftAmt), PIW, POW);
            pClz       = refClz(int'(pClzData), PCW);
        end
        #1;
        checkAll(tag);
        $display("txn %-10s v=%0d sd=%0h sa=%0d cd=%0h -> so=%0h st=%0d sa=%0d clz=%0d | pad so=%0h st=%0d sa=%0d clz=%0d",
                 tag, inValid, shiftData, shiftAmt, clzData, shiftOut, sticky, stickyAnd,
                 clzCount, pShiftOut, pSticky, pStickyAnd, pClzCount);
    endtask

    task automatic applyCycle(input string tag, input logic v,
                              input logic [IW-1:0] sd, input logic [SW-1:0] sa,
                              input logic [CW-1:0] cd,
                              input logic [PIW-1:0] psd, input logic [PSW-1:0] psa,
                              input logic [PCW-1:0] pcd);
        @(negedge clock);
        inValid = v;
        shiftData = sd; shiftAmt = sa; clzData = cd;
        pShiftData = psd; pShiftAmt = psa; pClzData = pcd;
        sampleAndCheck(tag);
    endtask

    initial begin
        clearModel();
        randomizeInputs();

        // ---- reset held with valid inputs active ----
        resetn  = 1'b0;
        inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            randomizeInputs();
            @(posedge clock);
            #1;
            checkAll("reset");
        end

        // release; the first valid input is registered on the next edge
        @(negedge clock);
        resetn = 1'b1;
        randomizeInputs();
        sampleAndCheck("release");
        checkVal("release.out_valid_one", 32'(outValid), 32'd1);

        // ---- directed shift cases, default instance ----
        applyCycle("shift3", 1'b1, 8'b1011_0110, 4'd3, 8'h00, 4'b1011, 3'd3, 5'd0);
        checkVal("shift3.so",  32'(shiftOut), 32'h16);
        checkVal("shift3.st",  32'(sticky), 32'd1);
        checkVal("shift3.sa",  32'(stickyAnd), 32'd0);
        checkVal("clz00",      32'(clzCount), 32'd8);
        checkVal("pad3.so",    32'(pShiftOut), 32'b000101);
        checkVal("pad3.st",    32'(pSticky), 32'd1);
        checkVal("pad3.sa",    32'(pStickyAnd), 32'd0);
        checkVal("pclz0",      32'(pClzCount), 32'd5);

        applyCycle("shift0", 1'b1, 8'b1011_0110, 4'd0, 8'h01, 4'b1011, 3'd0, 5'h1F);
        checkVal("shift0.so",  32'(shiftOut), 32'hB6);
        checkVal("shift0.st",  32'(sticky), 32'd0);
        checkVal("shift0.sa",  32'(stickyAnd), 32'd1);
        checkVal("clz01",      32'(clzCount), 32'd7);
        checkVal("pad0.so",    32'(pShiftOut), 32'b101100);
        checkVal("pad0.st",    32'(pSticky), 32'd0);
        checkVal("pad0.sa",    32'(pStickyAnd), 32'd1);
        checkVal("pclz1f",     32'(pClzCount), 32'd0);

        applyCycle("satFF", 1'b1, 8'hFF, 4'd15, 8'h10, 4'hF, 3'd7, 5'h01);
        checkVal("satFF.so",   32'(shiftOut), 32'd0);
        checkVal("satFF.st",   32'(sticky), 32'd1);
        checkVal("satFF.sa",   32'(stickyAnd), 32'd1);
        checkVal("clz10",      32'(clzCount), 32'd3);
        // padding zeros are shifted out, so the AND must be 0
        checkVal("padSat.sa",  32'(pStickyAnd), 32'd0);
        checkVal("padSat.st",  32'(pSticky), 32'd1);

        applyCycle("sat80", 1'b1, 8'h80, 4'd8, 8'h80, 4'hF, 3'd2, 5'h02);
        checkVal("sat80.so",   32'(shiftOut), 32'd0);
        checkVal("sat80.st",   32'(sticky), 32'd1);
        checkVal("sat80.sa",   32'(stickyAnd), 32'd0);
        checkVal("clz80",      32'(clzCount), 32'd0);
        checkVal("padPad.sa",  32'(pStickyAnd), 32'd0);

        applyCycle("clzFF", 1'b1, 8'hFF, 4'd8, 8'hFF, 4'hF, 3'd6, 5'h10);
        checkVal("clzFF",      32'(clzCount), 32'd0);
        checkVal("all8.sa",    32'(stickyAnd), 32'd1);

        // ---- exhaustive CLZ sweep, back-to-back burst ----
        for (int d = 0; d < 256; d++) begin
            applyCycle("clzSweep", 1'b1, IW'($urandom), SW'($urandom), CW'(d),
                       PIW'($urandom), PSW'($urandom), PCW'(d));
        end

        // ---- hold: inputs change while in_valid is low ----
        for (int i = 0; i < 6; i++) begin
            applyCycle("hold", 1'b0, IW'($urandom), SW'($urandom), CW'($urandom),
                       PIW'($urandom), PSW'($urandom), PCW'($urandom));
        end

        // ---- randomized traffic with gaps ----
        for (int i = 0; i < 300; i++) begin
            applyCycle("random", 1'($urandom_range(0, 9) < 7), IW'($urandom),
                       SW'($urandom), CW'($urandom), PIW'($urandom),
                       PSW'($urandom), PCW'($urandom));
        end

        // ---- reset asserted mid-stream discards results ----
        @(negedge clock);
        resetn  = 1'b0;
        inValid = 1'b0;
        #1;
        clearModel();
        checkAll("midReset");
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyCycle("postReset", 1'b1, IW'($urandom), SW'($urandom), CW'($urandom),
                       PIW'($urandom), PSW'($urandom), PCW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/sticky_shift_clz_unit.md
Name: sticky_shift_clz_unit

Overview:
Registered datapath helper for the posit adder's alignment and normalization stages. It has two independent lanes:
- a right shifter that keeps sticky information (OR and AND of all bits shifted out), used to align the smaller fraction;
- a leading-zero counter, used to renormalize after subtraction.
Both lanes are combinational internally, with one register stage at the output and a valid flag.

Parameters:
- IN_WIDTH, 8: width of the shift-lane input.
- OUT_WIDTH, 8: width of the shift-lane output. Must be >= IN_WIDTH; elaboration fails otherwise.
- SHIFT_VAL_WIDTH, 4: width of the shift amount.
- CLZ_WIDTH, 8: width of the count-lane input.
- Derived CLZ_OUT_WIDTH = $clog2(CLZ_WIDTH+1).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  qualifies this cycle's inputs.
- shift_data  in  IN_WIDTH  value to shift right.
- shift_amt  in  SHIFT_VAL_WIDTH  unsigned shift distance.
- clz_data  in  CLZ_WIDTH  value whose leading zeros are counted.
- out_valid  out  1  results valid.
- shift_out  out  OUT_WIDTH  shifted value.
- sticky  out  1  OR of all bits shifted out.
- sticky_and  out  1  AND of all bits shifted out.
- clz_count  out  CLZ_OUT_WIDTH  number of leading zeros.

Behaviour:
- Reset: while resetn=0, all outputs are asynchronously forced to 0 (out_valid, shift_out, sticky, sticky_and, clz_count).
- Latency: exactly 1 cycle. Inputs sampled at edge N appear at outputs after edge N.
- out_valid <= in_valid every cycle.
- Result registers load only when in_valid=1; otherwise they hold their previous values.
- No backpressure; full throughput, one result per cycle.

Shift lane (combinational before the register):
- Form the extended value E = {shift_data, (OUT_WIDTH-IN_WIDTH) zeros}, i.e. the input is MSB-aligned to the output.
- Let s = shift_amt, zero-extended.
- shift_out = E >> s, with zeros filled at the MSB.
- sticky = OR of the bits of E at positions [s-1:0].
- sticky_and = AND of the bits of E at positions [s-1:0].
- s = 0: shift_out = E, sticky = 0, sticky_and = 1 (empty AND).
- s >= OUT_WIDTH: shift_out = 0, sticky = |E, sticky_and = &E. This saturates; there is no wrap-around.
- Padding zeros count as shifted-out bits. Any shift that reaches the padding therefore forces sticky_and = 0.

Count lane:
- clz_count = number of consecutive 0 bits starting at the MSB of clz_data.
- clz_data = 0 gives clz_count = CLZ_WIDTH.
- MSB set gives clz_count = 0.
- Implement as a priority encoder or log-tree; any structure meeting single-cycle timing is acceptable.

Lane independence and concurrency:
- The two lanes share only in_valid.
- Asserting reset mid-stream discards the in-flight result.
- After resetn deasserts, the first in_valid is registered on the next edge.

Test Plan:
- Reset: hold resetn=0 with in_valid=1 and random data, then release -> all outputs 0 during reset; out_valid=1 one cycle after the first sampled in_valid.
- Shift basic (IN=OUT=8): shift_data=8'b1011_0110, shift_amt=3 -> shift_out=8'b0001_0110, sticky=1, sticky_and=0. Same data, shift_amt=0 -> shift_out=8'b1011_0110, sticky=0, sticky_and=1.
- Shift saturation (IN=OUT=8): shift_data=8'hFF, shift_amt=15 -> shift_out=0, sticky=1, sticky_and=1. shift_data=8'h80, shift_amt=8 -> shift_out=0, sticky=1, sticky_and=0.
- Padded shift (IN=4, OUT=6): shift_data=4'b1011, shift_amt=3 -> E=6'b101100, shift_out=6'b000101, sticky=1, sticky_and=0. shift_amt=0 -> shift_out=6'b101100, sticky=0, sticky_and=1.
- CLZ (CLZ_WIDTH=8): 8'h00->8, 8'h01->7, 8'h10->3, 8'h80->0, 8'hFF->0. Then an exhaustive sweep against a reference model.
- Hold/valid: drive in_valid=0 with changing inputs -> outputs keep the last valid result and out_valid=0. A back-to-back in_valid burst produces one result per cycle in order.
